// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU memory-bus arbiter.
//   state_t    : sequencer states IDLE -> ISSUE -> WAIT
//   BUS_READ/BUS_WRITE : BUS_mode encodings
//   OWN_IF/OWN_LS      : owner ids (instruction fetch / load-store)
//   pick_owner : round-robin choice between the two requesters
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic BUS_READ  = 1'b0;
    localparam logic BUS_WRITE = 1'b1;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    // A lone requester wins; on a tie the one that did not own the bus last wins.
    function automatic logic pick_owner(input logic if_req, input logic ls_req,
                                        input logic last_owner);
        logic owner;
        if (if_req && ls_req) begin
            owner = (last_owner == OWN_IF) ? OWN_LS : OWN_IF;
        end else if (ls_req) begin
            owner = OWN_LS;
        end else begin
            owner = OWN_IF;
        end
        return owner;
    endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Watchdog counter for a pending bus transaction.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count (start of a transaction)
//   en         : one more cycle waited without completion
//   expired_c  : this waiting cycle brings the count to TIMEOUT (combinational)
module bus_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count waiting cycles; the FSM leaves WAIT on expiry so the count never passes TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expire in the cycle whose increment would reach TIMEOUT, so done lands TIMEOUT+1 after start.
    assign expired_c = en && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester arbiter and sequencer for the shared CPU memory bus.
//   IF port (if_*)  : read-only requester, req held until if_done
//   LS port (ls_*)  : read/write requester, req held until ls_done
//   BUS_* outputs   : one-cycle start, latched mode/addr/wdata
//   BUS_* inputs    : read data with rdata_valid, write_done strobe
//   busy            : high whenever not IDLE
// All outputs are registered; a watchdog aborts hung transactions with err=1.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic              BUS_start_transaction,
    output logic              BUS_mode,
    output logic [ADDR_W-1:0] BUS_addr,
    output logic [DATA_W-1:0] BUS_wdata,
    input  logic [DATA_W-1:0] BUS_rdata,
    input  logic              BUS_rdata_valid,
    input  logic              BUS_write_done,
    output logic              busy
);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              if_done_q, if_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_err_q, if_err_d;
    logic              ls_done_q, ls_done_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              ls_err_q, ls_err_d;

    logic              complete;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_expired_c;
    logic              fin;
    logic [DATA_W-1:0] fin_rdata;
    logic              fin_err;

    // Only the strobe matching the latched mode ends a transaction.
    assign complete = (mode_q == BUS_READ) ? BUS_rdata_valid : BUS_write_done;
    assign cnt_clr  = (state_q == ISSUE);
    assign cnt_en   = (state_q == WAIT) && !complete;

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .expired_c (cnt_expired_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mode_d       = mode_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        start_d      = 1'b0;
        if_done_d    = 1'b0;
        if_rdata_d   = if_rdata_q;
        if_err_d     = if_err_q;
        ls_done_d    = 1'b0;
        ls_rdata_d   = ls_rdata_q;
        ls_err_d     = ls_err_q;
        fin          = 1'b0;
        fin_rdata    = '0;
        fin_err      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (if_req || ls_req) begin
                    owner_d      = pick_owner(if_req, ls_req, last_owner_q);
                    last_owner_d = owner_d;
                    if (owner_d == OWN_LS) begin
                        mode_d  = ls_we ? BUS_WRITE : BUS_READ;
                        addr_d  = ls_addr;
                        wdata_d = ls_wdata;
                    end else begin
                        mode_d  = BUS_READ;
                        addr_d  = if_addr;
                        wdata_d = '0;
                    end
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Completion takes precedence over a timeout in the same cycle.
                if (complete) begin
                    fin       = 1'b1;
                    fin_rdata = (mode_q == BUS_READ) ? BUS_rdata : '0;
                end else if (cnt_expired_c) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fin) begin
            state_d = IDLE;
            if (owner_q == OWN_IF) begin
                if_done_d  = 1'b1;
                if_rdata_d = fin_rdata;
                if_err_d   = fin_err;
            end else begin
                ls_done_d  = 1'b1;
                ls_rdata_d = fin_rdata;
                ls_err_d   = fin_err;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            mode_q       <= BUS_READ;
            addr_q       <= '0;
            wdata_q      <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            if_done_q    <= 1'b0;
            if_rdata_q   <= '0;
            if_err_q     <= 1'b0;
            ls_done_q    <= 1'b0;
            ls_rdata_q   <= '0;
            ls_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mode_q       <= mode_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            if_done_q    <= if_done_d;
            if_rdata_q   <= if_rdata_d;
            if_err_q     <= if_err_d;
            ls_done_q    <= ls_done_d;
            ls_rdata_q   <= ls_rdata_d;
            ls_err_q     <= ls_err_d;
        end
    end

    assign BUS_start_transaction = start_q;
    assign BUS_mode              = mode_q;
    assign BUS_addr              = addr_q;
    assign BUS_wdata             = wdata_q;
    assign busy                  = busy_q;
    assign if_done               = if_done_q;
    assign if_rdata              = if_rdata_q;
    assign if_err                = if_err_q;
    assign ls_done               = ls_done_q;
    assign ls_rdata              = ls_rdata_q;
    assign ls_err                = ls_err_q;

endmodule
